// File: rtl/cpu_pkg.sv
// Shared types for the hazard/forwarding control slice: FSM states,
// the destination-register tag carried down the pipe, and tag helpers.
package cpu_pkg;

    localparam int REG_W = 32'sd4;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        FLUSH    = 2'd2
    } hz_state_e;

    // Field order matters: {wr, wb} occupy the MSBs so later stages can
    // keep only that prefix once the load flag is no longer needed.
    typedef struct packed {
        logic [REG_W-1:0] wr;
        logic             wb;
        logic             load;
    } wb_tag_t;

    localparam int TAG_W = $bits(wb_tag_t);

    localparam wb_tag_t BUBBLE_TAG = '{wr: {REG_W{1'b0}}, wb: 1'b0, load: 1'b0};

    // Register 0 is hardwired zero, so a write to it must never look like
    // a producer to the forwarding unit or the load-use check.
    function automatic wb_tag_t sanitize_tag(input wb_tag_t t);
        wb_tag_t r;
        r = t;
        if (t.wr == {REG_W{1'b0}}) begin
            r.wb = 1'b0;
        end else begin
            r.wb = t.wb;
        end
        return r;
    endfunction

endpackage

// File: rtl/tag_stage.sv
// One pipeline register for a destination tag. Holds a full wb_tag_t at
// ID/EX, or only its {wr, wb} prefix downstream where the load flag is dead.
module tag_stage
    import cpu_pkg::*;
#(
    parameter int W = TAG_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         bubble,
    input  logic [W-1:0] tag_in,
    output logic [W-1:0] tag_out
);

    localparam logic [TAG_W-1:0] BUBBLE_BITS = BUBBLE_TAG;

    logic [W-1:0] tag_d;
    logic [W-1:0] tag_q;

    // Choose between the incoming tag and a bubble for the next edge.
    always_comb begin
        if (bubble) begin
            tag_d = BUBBLE_BITS[TAG_W-1 -: W];
        end else begin
            tag_d = tag_in;
        end
    end

    // Tag register, cleared to a bubble by asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_q <= BUBBLE_BITS[TAG_W-1 -: W];
        end else begin
            tag_q <= tag_d;
        end
    end

    assign tag_out = tag_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Producer side of operand forwarding: carries destination tags through
// ID/EX, EX/MEM and MEM/WB, detects load-use hazards (stall + bubble),
// applies branch-taken flushes, and counts stall and flush cycles.
module hazard_ctrl
    import cpu_pkg::*;
#(
    parameter int REG_W = 32'sd4,
    parameter int CNT_W = 32'sd16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic [REG_W-1:0] id_wr,
    input  logic             id_wb,
    input  logic             id_load,
    input  logic             ex_br_taken,
    output logic [REG_W-1:0] id_ex_wr,
    output logic             id_ex_wb,
    output logic [REG_W-1:0] ex_mem_wr,
    output logic             ex_mem_wb,
    output logic [REG_W-1:0] mem_wb_wr,
    output logic             mem_wb_wb,
    output logic             pc_hold,
    output logic             flush_if_id,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    // Past ID/EX only {wr, wb} are carried; the load flag matters only for
    // the load-use check against the instruction directly behind it.
    localparam int LINK_W = TAG_W - 32'sd1;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    hz_state_e         state_q;
    hz_state_e         state_d;
    wb_tag_t           id_raw_s;
    wb_tag_t           id_tag_s;
    wb_tag_t           id_ex_s;
    logic [TAG_W-1:0]  id_ex_bits_s;
    logic [LINK_W-1:0] ex_mem_bits_s;
    logic [LINK_W-1:0] mem_wb_bits_s;
    logic              id_valid_eff_s;
    logic              lu_hit_s;
    logic              bubble_s;
    logic              pc_hold_s;
    logic              flush_s;
    logic [CNT_W-1:0]  stall_cnt_d;
    logic [CNT_W-1:0]  stall_cnt_q;
    logic [CNT_W-1:0]  flush_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q;

    assign id_ex_s = wb_tag_t'(id_ex_bits_s);

    // Build the ID tag (wrong-path instructions masked) and the load-use hit.
    always_comb begin
        id_valid_eff_s = id_valid & (state_q != FLUSH);
        id_raw_s.wr    = id_wr;
        id_raw_s.wb    = id_wb & id_valid_eff_s;
        id_raw_s.load  = id_load & id_valid_eff_s;
        id_tag_s       = sanitize_tag(id_raw_s);
        lu_hit_s       = id_valid_eff_s & id_ex_s.load & id_ex_s.wb &
                         (id_ex_s.wr != {REG_W{1'b0}}) &
                         ((id_rs1_used & (id_rs1 == id_ex_s.wr)) |
                          (id_rs2_used & (id_rs2 == id_ex_s.wr)));
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: flush wins over a stall, each special state lasts one cycle.
    always_comb begin
        state_d = RUN;
        case (state_q)
            RUN, LU_STALL: begin
                if (ex_br_taken) begin
                    state_d = FLUSH;
                end else if (lu_hit_s) begin
                    state_d = LU_STALL;
                end else begin
                    state_d = RUN;
                end
            end
            FLUSH:   state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // FSM outputs: flush/stall requests and the ID/EX bubble select.
    // In FLUSH the branch input is ignored because EX holds a bubble.
    always_comb begin
        flush_s   = 1'b0;
        pc_hold_s = 1'b0;
        bubble_s  = 1'b0;
        case (state_q)
            RUN, LU_STALL: begin
                if (ex_br_taken) begin
                    flush_s  = 1'b1;
                    bubble_s = 1'b1;
                end else if (lu_hit_s) begin
                    pc_hold_s = 1'b1;
                    bubble_s  = 1'b1;
                end else begin
                    bubble_s = 1'b0;
                end
            end
            FLUSH:   bubble_s = 1'b1;
            default: bubble_s = 1'b1;
        endcase
    end

    // Saturating next values for the stall and flush counters.
    always_comb begin
        if (pc_hold_s && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
        if (flush_s && (flush_cnt_q != CNT_MAX)) begin
            flush_cnt_d = flush_cnt_q + CNT_ONE;
        end else begin
            flush_cnt_d = flush_cnt_q;
        end
    end

    // Performance counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= {CNT_W{1'b0}};
            flush_cnt_q <= {CNT_W{1'b0}};
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    tag_stage #(.W(TAG_W)) u_id_ex (
        .clk     (clk),
        .rst_n   (rst_n),
        .bubble  (bubble_s),
        .tag_in  (id_tag_s),
        .tag_out (id_ex_bits_s)
    );

    tag_stage #(.W(LINK_W)) u_ex_mem (
        .clk     (clk),
        .rst_n   (rst_n),
        .bubble  (1'b0),
        .tag_in  (id_ex_bits_s[TAG_W-1:1]),
        .tag_out (ex_mem_bits_s)
    );

    tag_stage #(.W(LINK_W)) u_mem_wb (
        .clk     (clk),
        .rst_n   (rst_n),
        .bubble  (1'b0),
        .tag_in  (ex_mem_bits_s),
        .tag_out (mem_wb_bits_s)
    );

    assign id_ex_wr    = id_ex_s.wr;
    assign id_ex_wb    = id_ex_s.wb;
    assign ex_mem_wr   = ex_mem_bits_s[LINK_W-1:1];
    assign ex_mem_wb   = ex_mem_bits_s[0];
    assign mem_wb_wr   = mem_wb_bits_s[LINK_W-1:1];
    assign mem_wb_wb   = mem_wb_bits_s[0];
    // Requests are held off while in reset so a stray branch input cannot leak out.
    assign pc_hold     = pc_hold_s & rst_n;
    assign flush_if_id = flush_s & rst_n;
    assign stall_cnt   = stall_cnt_q;
    assign flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed, table-driven bench for hazard_ctrl plus hand-written sequences
// for counter saturation and asynchronous reset in the middle of a stall.
`timescale 1ns/1ps
module tb_hazard_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       id_valid, id_rs1_used, id_rs2_used, id_wb, id_load, ex_br_taken;
    logic [3:0] id_rs1, id_rs2, id_wr;

    logic [3:0]  id_ex_wr, ex_mem_wr, mem_wb_wr;
    logic        id_ex_wb, ex_mem_wb, mem_wb_wb, pc_hold, flush_if_id;
    logic [15:0] stall_cnt, flush_cnt;

    logic [3:0] s_id_ex_wr, s_ex_mem_wr, s_mem_wb_wr;
    logic       s_id_ex_wb, s_ex_mem_wb, s_mem_wb_wb, s_pc_hold, s_flush_if_id;
    logic [1:0] s_stall_cnt, s_flush_cnt;

    hazard_ctrl #(.REG_W(4), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_wr(id_wr), .id_wb(id_wb),
        .id_load(id_load), .ex_br_taken(ex_br_taken),
        .id_ex_wr(id_ex_wr), .id_ex_wb(id_ex_wb), .ex_mem_wr(ex_mem_wr), .ex_mem_wb(ex_mem_wb),
        .mem_wb_wr(mem_wb_wr), .mem_wb_wb(mem_wb_wb), .pc_hold(pc_hold),
        .flush_if_id(flush_if_id), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    hazard_ctrl #(.REG_W(4), .CNT_W(2)) dut_s (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_wr(id_wr), .id_wb(id_wb),
        .id_load(id_load), .ex_br_taken(ex_br_taken),
        .id_ex_wr(s_id_ex_wr), .id_ex_wb(s_id_ex_wb), .ex_mem_wr(s_ex_mem_wr),
        .ex_mem_wb(s_ex_mem_wb), .mem_wb_wr(s_mem_wb_wr), .mem_wb_wb(s_mem_wb_wb),
        .pc_hold(s_pc_hold), .flush_if_id(s_flush_if_id),
        .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        logic v; logic [3:0] rs1; logic [3:0] rs2; logic u1; logic u2;
        logic [3:0] wr; logic wb; logic ld; logic br;
        logic [3:0] iw; logic ib; logic [3:0] ew; logic eb; logic [3:0] mw; logic mb;
        logic ph; logic fl; int sc; int fc;
    } vec_t;

    function automatic vec_t mk(input logic v, input logic [3:0] rs1, input logic [3:0] rs2,
                                input logic u1, input logic u2, input logic [3:0] wr,
                                input logic wb, input logic ld, input logic br,
                                input logic [3:0] iw, input logic ib, input logic [3:0] ew,
                                input logic eb, input logic [3:0] mw, input logic mb,
                                input logic ph, input logic fl, input int sc, input int fc);
        vec_t t;
        t.v = v; t.rs1 = rs1; t.rs2 = rs2; t.u1 = u1; t.u2 = u2;
        t.wr = wr; t.wb = wb; t.ld = ld; t.br = br;
        t.iw = iw; t.ib = ib; t.ew = ew; t.eb = eb; t.mw = mw; t.mb = mb;
        t.ph = ph; t.fl = fl; t.sc = sc; t.fc = fc;
        return t;
    endfunction

    task automatic drive(input logic v, input logic [3:0] rs1, input logic [3:0] rs2,
                         input logic u1, input logic u2, input logic [3:0] wr,
                         input logic wb, input logic ld, input logic br);
        @(posedge clk);
        #1;
        id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rs1_used = u1; id_rs2_used = u2;
        id_wr = wr; id_wb = wb; id_load = ld; ex_br_taken = br;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " id_ex_wr"},  {28'd0, id_ex_wr},  32'd0);
        check({tag, " id_ex_wb"},  {31'd0, id_ex_wb},  32'd0);
        check({tag, " ex_mem_wr"}, {28'd0, ex_mem_wr}, 32'd0);
        check({tag, " ex_mem_wb"}, {31'd0, ex_mem_wb}, 32'd0);
        check({tag, " mem_wb_wr"}, {28'd0, mem_wb_wr}, 32'd0);
        check({tag, " mem_wb_wb"}, {31'd0, mem_wb_wb}, 32'd0);
        check({tag, " pc_hold"},   {31'd0, pc_hold},   32'd0);
        check({tag, " flush"},     {31'd0, flush_if_id}, 32'd0);
        check({tag, " stall_cnt"}, {16'd0, stall_cnt}, 32'd0);
        check({tag, " flush_cnt"}, {16'd0, flush_cnt}, 32'd0);
        check({tag, " s_stall_cnt"}, {30'd0, s_stall_cnt}, 32'd0);
        check({tag, " s_pc_hold"}, {31'd0, s_pc_hold}, 32'd0);
    endtask

    vec_t vecs[19];

    initial begin
        //             v rs1  rs2  u1 u2 wr   wb ld br | iw   ib ew   eb mw   mb ph fl sc fc
        vecs[0]  = mk(1, 4'd0, 4'd0, 0, 0, 4'd5, 1, 0, 0, 4'd0, 0, 4'd0, 0, 4'd0, 0, 0, 0, 0, 0);
        vecs[1]  = mk(0, 4'd0, 4'd0, 0, 0, 4'd0, 0, 0, 0, 4'd5, 1, 4'd0, 0, 4'd0, 0, 0, 0, 0, 0);
        vecs[2]  = mk(0, 4'd0, 4'd0, 0, 0, 4'd0, 0, 0, 0, 4'd0, 0, 4'd5, 1, 4'd0, 0, 0, 0, 0, 0);
        vecs[3]  = mk(1, 4'd0, 4'd0, 0, 0, 4'd3, 1, 1, 0, 4'd0, 0, 4'd0, 0, 4'd5, 1, 0, 0, 0, 0);
        vecs[4]  = mk(1, 4'd3, 4'd2, 1, 1, 4'd4, 1, 0, 0, 4'd3, 1, 4'd0, 0, 4'd0, 0, 1, 0, 0, 0);
        vecs[5]  = mk(1, 4'd3, 4'd2, 1, 1, 4'd4, 1, 0, 0, 4'd0, 0, 4'd3, 1, 4'd0, 0, 0, 0, 1, 0);
        vecs[6]  = mk(1, 4'd0, 4'd0, 0, 0, 4'd0, 1, 1, 0, 4'd4, 1, 4'd0, 0, 4'd3, 1, 0, 0, 1, 0);
        vecs[7]  = mk(1, 4'd0, 4'd0, 1, 1, 4'd6, 1, 0, 0, 4'd0, 0, 4'd4, 1, 4'd0, 0, 0, 0, 1, 0);
        vecs[8]  = mk(1, 4'd0, 4'd0, 0, 0, 4'd3, 1, 1, 0, 4'd6, 1, 4'd0, 0, 4'd4, 1, 0, 0, 1, 0);
        vecs[9]  = mk(1, 4'd1, 4'd3, 1, 0, 4'd7, 1, 0, 0, 4'd3, 1, 4'd6, 1, 4'd0, 0, 0, 0, 1, 0);
        vecs[10] = mk(1, 4'd0, 4'd0, 0, 0, 4'd2, 1, 1, 0, 4'd7, 1, 4'd3, 1, 4'd6, 1, 0, 0, 1, 0);
        vecs[11] = mk(1, 4'd0, 4'd2, 0, 1, 4'd8, 1, 0, 1, 4'd2, 1, 4'd7, 1, 4'd3, 1, 0, 1, 1, 0);
        vecs[12] = mk(1, 4'd0, 4'd0, 0, 0, 4'd9, 1, 0, 1, 4'd0, 0, 4'd2, 1, 4'd7, 1, 0, 0, 1, 1);
        vecs[13] = mk(0, 4'd0, 4'd0, 0, 0, 4'd0, 0, 0, 0, 4'd0, 0, 4'd0, 0, 4'd2, 1, 0, 0, 1, 1);
        vecs[14] = mk(1, 4'd0, 4'd0, 0, 0, 4'd5, 1, 1, 0, 4'd0, 0, 4'd0, 0, 4'd0, 0, 0, 0, 1, 1);
        vecs[15] = mk(1, 4'd5, 4'd0, 1, 0, 4'd6, 1, 0, 0, 4'd5, 1, 4'd0, 0, 4'd0, 0, 1, 0, 1, 1);
        vecs[16] = mk(1, 4'd5, 4'd0, 1, 0, 4'd6, 1, 0, 1, 4'd0, 0, 4'd5, 1, 4'd0, 0, 0, 1, 2, 1);
        vecs[17] = mk(1, 4'd0, 4'd0, 0, 0, 4'd10, 1, 0, 0, 4'd0, 0, 4'd0, 0, 4'd5, 1, 0, 0, 2, 2);
        vecs[18] = mk(0, 4'd0, 4'd0, 0, 0, 4'd0, 0, 0, 0, 4'd0, 0, 4'd0, 0, 4'd0, 0, 0, 0, 2, 2);

        rst_n = 1'b0;
        id_valid = 1'b0; id_rs1 = 4'd0; id_rs2 = 4'd0; id_rs1_used = 1'b0; id_rs2_used = 1'b0;
        id_wr = 4'd0; id_wb = 1'b0; id_load = 1'b0; ex_br_taken = 1'b0;

        // Reset held low with random inputs: everything stays at zero.
        for (int r = 0; r < 4; r++) begin
            drive(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
            @(negedge clk);
            check_reset_state($sformatf("rst%0d", r));
        end

        // Release reset with a NOP in ID.
        drive(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        check("release pc_hold", {31'd0, pc_hold}, 32'd0);
        check("release flush", {31'd0, flush_if_id}, 32'd0);

        // Table: latency, load-use, r0 dest, unused source, flush vs stall, masking.
        for (int i = 0; i < 19; i++) begin
            drive(vecs[i].v, vecs[i].rs1, vecs[i].rs2, vecs[i].u1, vecs[i].u2,
                  vecs[i].wr, vecs[i].wb, vecs[i].ld, vecs[i].br);
            @(negedge clk);
            check($sformatf("v%0d id_ex_wr", i),  {28'd0, id_ex_wr},  {28'd0, vecs[i].iw});
            check($sformatf("v%0d id_ex_wb", i),  {31'd0, id_ex_wb},  {31'd0, vecs[i].ib});
            check($sformatf("v%0d ex_mem_wr", i), {28'd0, ex_mem_wr}, {28'd0, vecs[i].ew});
            check($sformatf("v%0d ex_mem_wb", i), {31'd0, ex_mem_wb}, {31'd0, vecs[i].eb});
            check($sformatf("v%0d mem_wb_wr", i), {28'd0, mem_wb_wr}, {28'd0, vecs[i].mw});
            check($sformatf("v%0d mem_wb_wb", i), {31'd0, mem_wb_wb}, {31'd0, vecs[i].mb});
            check($sformatf("v%0d pc_hold", i),   {31'd0, pc_hold},   {31'd0, vecs[i].ph});
            check($sformatf("v%0d flush", i),     {31'd0, flush_if_id}, {31'd0, vecs[i].fl});
            check($sformatf("v%0d stall_cnt", i), {16'd0, stall_cnt}, vecs[i].sc);
            check($sformatf("v%0d flush_cnt", i), {16'd0, flush_cnt}, vecs[i].fc);
            check($sformatf("v%0d s_stall_cnt", i), {30'd0, s_stall_cnt}, vecs[i].sc);
            check($sformatf("v%0d s_flush_cnt", i), {30'd0, s_flush_cnt}, vecs[i].fc);
        end

        // Saturation: three more load-use stalls; the 2-bit counter stops at 3.
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 4'd1, 1'b1, 1'b1, 1'b0);
            drive(1'b1, 4'd1, 4'd0, 1'b1, 1'b0, 4'd2, 1'b1, 1'b0, 1'b0);
            @(negedge clk);
            check($sformatf("sat%0d pc_hold", k), {31'd0, pc_hold}, 32'd1);
            drive(1'b1, 4'd1, 4'd0, 1'b1, 1'b0, 4'd2, 1'b1, 1'b0, 1'b0);
            @(negedge clk);
            check($sformatf("sat%0d stall_cnt", k), {16'd0, stall_cnt}, 32'd3 + 32'(k));
            check($sformatf("sat%0d s_stall_cnt", k), {30'd0, s_stall_cnt}, 32'd3);
        end

        // Async reset while in LU_STALL: counters clear without a clock edge.
        drive(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 4'd1, 1'b1, 1'b1, 1'b0);
        drive(1'b1, 4'd1, 4'd0, 1'b1, 1'b0, 4'd2, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 4'd1, 4'd0, 1'b1, 1'b0, 4'd2, 1'b1, 1'b0, 1'b0);
        check("lus stall_cnt before", {16'd0, stall_cnt}, 32'd6);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_state("lus_rst");
        check("lus_rst s_flush_cnt", {30'd0, s_flush_cnt}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("post_rst pc_hold", {31'd0, pc_hold}, 32'd0);
        check("post_rst flush", {31'd0, flush_if_id}, 32'd0);

        // Async reset while pc_hold is high drops the stall request at once.
        drive(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 4'd7, 1'b1, 1'b1, 1'b0);
        drive(1'b1, 4'd0, 4'd7, 1'b0, 1'b1, 4'd8, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        check("hold pc_hold", {31'd0, pc_hold}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("hold_rst pc_hold", {31'd0, pc_hold}, 32'd0);
        check("hold_rst s_pc_hold", {31'd0, s_pc_hold}, 32'd0);
        check("hold_rst id_ex_wr", {28'd0, id_ex_wr}, 32'd0);
        #2;
        rst_n = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
